// File: rtl/decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decoder_pkg: shared sizing helpers, mode constants, one-hot helper |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package decoder_pkg;

  localparam int MAX_SEL_W    = 8;
  localparam int MAX_OUT_W    = 1 << MAX_SEL_W;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_ONESHOT = 1;

  function automatic int out_width(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_OUT_W-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decoder_core: combinational SEL_W to 2**SEL_W one-hot decoder      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module decoder_core
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  localparam int OUT_W = out_width(SEL_W)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out
);

  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign out[i] = (sel == SEL_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decoder_seq: registered one-hot decoder with load/clear/step state |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int LAST    = (1 << SEL_W) - 1,
  parameter int ONESHOT = MODE_WRAP,
  localparam int OUT_W  = out_width(SEL_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             en,
  output logic [SEL_W-1:0] state,
  output logic [OUT_W-1:0] out,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  localparam logic [SEL_W-1:0] LAST_S     = SEL_W'(LAST);
  localparam bit               IS_ONESHOT = (ONESHOT == MODE_ONESHOT);

  logic [SEL_W-1:0] state_d, state_q;
  logic [OUT_W-1:0] out_d, out_q;
  logic             wrap_d, wrap_q;
  logic             done_d, done_q;
  logic             load_err_d, load_err_q;

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      state_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      // An out-of-range load is rejected outright; en on that edge is dropped too.
      if (load_val > LAST_S) begin
        load_err_d = 1'b1;
      end else begin
        state_d = load_val;
        done_d  = 1'b0;
      end
    end else if (en) begin
      if (state_q == LAST_S) begin
        if (IS_ONESHOT) begin
          done_d = 1'b1;
        end else begin
          state_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        state_d = state_q + SEL_W'(1);
        if (IS_ONESHOT && (state_d == LAST_S)) begin
          done_d = 1'b1;
        end
      end
    end
  end

  // Decode the next state so out_q lines up with state_q on the same edge.
  decoder_core #(
    .SEL_W(SEL_W)
  ) u_core (
    .sel(state_d),
    .out(out_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= '0;
      out_q      <= OUT_W'(1);
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign state    = state_q;
  assign out      = out_q;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire
